rotating_square_gen: RTL and testbench
======================================

ROTATING_SQUARE_GEN -- requirements
Module: rotating_square_gen

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of seven-segment digits; legal range 2..8.
REQ-002 SHALL have parameter PRESC_W, default 24, prescaler width in bits; minimum 4.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  1 = square rotates; 0 = square paused at its current position.
REQ-006 SHALL have port dir  input  1  0 = clockwise (CW), 1 = counter-clockwise (CCW).
REQ-007 SHALL have port speed  input  2  rotation rate select; 3 = fastest.
REQ-008 SHALL have port an  output  NUM_DIGITS  digit enables, active-low; an[NUM_DIGITS-1] = leftmost digit.
REQ-009 SHALL have port sseg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-010 SHALL hold a position register pos, width clog2(2*NUM_DIGITS), range 0..2*NUM_DIGITS-1.
REQ-011 SHALL hold a prescaler that increments by 1 per cycle while en=1 and wraps at 2^PRESC_W.
REQ-012 SHALL assert tick when en=1 and the low (PRESC_W-speed) prescaler bits are all ones; tick period = 2^(PRESC_W-speed) cycles.
REQ-013 SHALL apply a speed change on the next cycle's comparison, with no prescaler reset.
REQ-014 SHALL, on tick with dir=0, set pos to pos+1 modulo 2*NUM_DIGITS (wrap 2N-1 -> 0).
REQ-015 SHALL, on tick with dir=1, set pos to pos-1 modulo 2*NUM_DIGITS (wrap 0 -> 2N-1).
REQ-016 SHALL sample dir on the tick cycle itself, so a dir change coincident with tick applies to that step.
REQ-017 SHALL, for pos<N, enable digit NUM_DIGITS-1-pos with sseg=SEG_UPPER (0x9C: segments a,b,f,g lit).
REQ-018 SHALL, for pos>=N, enable digit pos-N with sseg=SEG_LOWER (0xA3: segments c,d,e,g lit).
REQ-019 SHALL drive exactly one an bit low at all times; all other an bits high.
REQ-020 SHALL register an and sseg, decoded from next-pos, so both change on the same edge as pos (zero extra latency).
REQ-021 SHALL hold pos when en=0; no steps are lost or buffered across a pause.

Reset
REQ-022 SHALL, at the edge where reset=1, set pos=0 and prescaler=0.
REQ-023 SHALL, at the same edge, set an = all ones except an[NUM_DIGITS-1]=0, and set sseg=0x9C.
REQ-024 SHALL give reset priority over en, dir and speed, including mid-rotation.
REQ-025 SHALL place the first tick after reset release 2^(PRESC_W-speed) enabled cycles later.

Configuration
REQ-026 SHALL support macro ROTSQ_PAUSE_FLASH_EN.
REQ-027 SHALL, when ROTSQ_PAUSE_FLASH_EN is defined and en=0:
- keep the prescaler running;
- keep pos held;
- blank sseg to 0xFF while prescaler MSB=1;
- keep an unchanged.
REQ-028 SHALL, when ROTSQ_PAUSE_FLASH_EN is defined, show a steady pattern from the first edge with en=1.
REQ-029 SHALL, when ROTSQ_PAUSE_FLASH_EN is undefined, freeze the prescaler at en=0 and hold sseg steady.

Structure
REQ-030 SHALL place the following in package rotsq_pkg:
- constants SEG_UPPER=8'h9C, SEG_LOWER=8'hA3, SEG_BLANK=8'hFF;
- DIR_CW=0, DIR_CCW=1.
REQ-031 SHALL implement prescaler and tick generation in sub-module rotsq_tick_gen (ports clk, reset, en, speed, tick, msb).

Verification (NUM_DIGITS=4, PRESC_W=4)
REQ-032 SHALL cover CW full lap:
- stimulus: reset, then en=1, dir=0, speed=3;
- required: tick every 2 cycles;
- an sequence 0111, 1011, 1101, 1110 with sseg=0x9C;
- then 1110, 1101, 1011, 0111 with sseg=0xA3;
- then back to 0111/0x9C.
REQ-033 SHALL cover CCW wrap: from reset, dir=1, speed=3 -> first step gives pos=7, an=0111, sseg=0xA3; next step gives an=1011, sseg=0xA3.
REQ-034 SHALL cover pause: en=0 for 40 cycles mid-lap.
- Without macro: an and sseg constant.
- With macro: sseg alternates pattern/0xFF every 8 cycles.
- Both: resume continues from the held position.
REQ-035 SHALL cover speed: speed=0 -> steps exactly 16 cycles apart; switching to speed=2 -> steps 4 cycles apart with no skipped position.
REQ-036 SHALL cover reset mid-run: reset=1 for one cycle at pos=5 -> next edge gives an=0111, sseg=0x9C; first step after release comes 2^(4-speed) cycles later.
REQ-037 SHALL cover dir toggle coincident with tick: at pos=2, dir goes 0->1 on the tick cycle -> pos=1 (an=1011, sseg=0x9C).

Source files
------------

// File: rtl/rotsq_pkg.sv
// Shared constants for the rotating-square display generator.
// Segment encodings are active-low, ordered {dp,g,f,e,d,c,b,a}.
package rotsq_pkg;

  localparam logic [7:0] SEG_UPPER = 8'h9C;
  localparam logic [7:0] SEG_LOWER = 8'hA3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_e;

endpackage

// File: rtl/rotsq_tick_gen.sv
// Free-running prescaler producing a rotation tick at a selectable rate.
// With ROTSQ_PAUSE_FLASH_EN defined the prescaler keeps counting while paused.
module rotsq_tick_gen #(
  parameter int PRESC_W = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick,
  output logic       msb
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic [PRESC_W-1:0] mask;

  // Higher speed shortens the all-ones window the tick waits for.
  always_comb begin
    mask    = {PRESC_W{1'b1}} >> speed;
    tick    = en && ((presc_q & mask) == mask);
    presc_d = presc_q;
`ifdef ROTSQ_PAUSE_FLASH_EN
    presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
`else
    if (en) begin
      presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
`endif
  end

  assign msb = presc_q[PRESC_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/rotating_square_gen.sv
// Rotating square around a multi-digit seven-segment display (upper square, then lower).
// Optional ROTSQ_PAUSE_FLASH_EN flashes the square while rotation is paused.
module rotating_square_gen
  import rotsq_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESC_W    = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            speed,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            sseg
);

  localparam int POS_W = $clog2(2 * NUM_DIGITS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * NUM_DIGITS - 1);
  localparam logic [POS_W-1:0] POS_HALF = POS_W'(NUM_DIGITS);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic                  tick;
  logic                  presc_msb;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;
  logic [POS_W-1:0]      digit;
  logic                  upper;

  rotsq_tick_gen #(
    .PRESC_W(PRESC_W)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .speed(speed),
    .tick (tick),
    .msb  (presc_msb)
  );

`ifndef ROTSQ_PAUSE_FLASH_EN
  logic unused_msb;
  assign unused_msb = presc_msb;
`endif

  // Outputs decode from the next position so they move on the same edge as pos.
  always_comb begin
    pos_d = pos_q;
    if (tick) begin
      if (dir == DIR_CCW) begin
        pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_ONE;
      end else begin
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
      end
    end
    upper = (pos_d < POS_HALF);
    digit = upper ? (POS_HALF - POS_ONE - pos_d) : (pos_d - POS_HALF);
    an_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = (digit != POS_W'(i));
    end
    sseg_d = upper ? SEG_UPPER : SEG_LOWER;
`ifdef ROTSQ_PAUSE_FLASH_EN
    if (!en && presc_msb) begin
      sseg_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q  <= '0;
      an_q   <= {1'b0, {(NUM_DIGITS-1){1'b1}}};
      sseg_q <= SEG_UPPER;
    end else begin
      pos_q  <= pos_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_rotating_square_gen.sv
// Self-checking bench for rotating_square_gen (NUM_DIGITS=4, PRESC_W=4).
// Honours ROTSQ_PAUSE_FLASH_EN in its reference model when defined.
module tb_rotating_square_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       dir;
  logic [1:0] speed;
  logic [3:0] an;
  logic [7:0] sseg;

  rotating_square_gen #(
    .NUM_DIGITS(4),
    .PRESC_W   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .dir  (dir),
    .speed(speed),
    .an   (an),
    .sseg (sseg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    string      name;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] speed;
    logic [3:0] an;
    logic [7:0] sseg;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  logic [3:0] m_presc;
  logic [2:0] m_pos;
  logic       m_blank;

  // Reference model: advances one clock with the given inputs.
  task automatic stepModel(input logic r, input logic e, input logic d, input logic [1:0] s);
    logic [3:0] mask;
    logic       tk;
    if (r) begin
      m_pos   = 3'd0;
      m_presc = 4'd0;
      m_blank = 1'b0;
    end else begin
      mask    = 4'hF >> s;
      tk      = e && ((m_presc & mask) == mask);
      m_blank = 1'b0;
`ifdef ROTSQ_PAUSE_FLASH_EN
      m_blank = !e && m_presc[3];
      m_presc = m_presc + 4'd1;
`else
      if (e) m_presc = m_presc + 4'd1;
`endif
      if (tk) m_pos = d ? m_pos - 3'd1 : m_pos + 3'd1;
    end
  endtask

  function automatic exp_t modelExp(input string name);
    exp_t x;
    x.name = name;
    if (m_pos < 3'd4) begin
      x.an   = ~(4'b1000 >> m_pos);
      x.sseg = 8'h9C;
    end else begin
      x.an   = ~(4'b0001 << (m_pos - 3'd4));
      x.sseg = 8'hA3;
    end
    if (m_blank) x.sseg = 8'hFF;
    return x;
  endfunction

  task automatic checkOutput();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_empty: no expectation queued");
      return;
    end
    x = sb.pop_front();
    checks++;
    if (an === x.an && sseg === x.sseg) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got an=%b sseg=%h, want an=%b sseg=%h",
               x.name, an, sseg, x.an, x.sseg);
    end
  endtask

  // Drives one cycle, queues the expectation, clocks and compares.
  task automatic applyStimulus(input logic r, input logic e, input logic d, input logic [1:0] s,
                               input logic use_exp, input logic [3:0] x_an,
                               input logic [7:0] x_sseg, input string name);
    exp_t x;
    reset = r;
    en    = e;
    dir   = d;
    speed = s;
    stepModel(r, e, d, s);
    if (use_exp) begin
      x.an   = x_an;
      x.sseg = x_sseg;
      x.name = name;
    end else begin
      x = modelExp(name);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runModel(input logic r, input logic e, input logic d, input logic [1:0] s,
                          input int n, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(r, e, d, s, 1'b0, 4'h0, 8'h00, name);
    end
  endtask

  vec_t cw_lap[17];
  vec_t ccw[5];

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    dir   = 1'b0;
    speed = 2'd0;
    m_presc = '0;
    m_pos   = '0;
    m_blank = 1'b0;

    cw_lap[0]  = '{1'b1, 1'b1, 1'b0, 2'd3, 4'b0111, 8'h9C};
    cw_lap[1]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b0111, 8'h9C};
    cw_lap[2]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1011, 8'h9C};
    cw_lap[3]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1011, 8'h9C};
    cw_lap[4]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1101, 8'h9C};
    cw_lap[5]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1101, 8'h9C};
    cw_lap[6]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1110, 8'h9C};
    cw_lap[7]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1110, 8'h9C};
    cw_lap[8]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1110, 8'hA3};
    cw_lap[9]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1110, 8'hA3};
    cw_lap[10] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1101, 8'hA3};
    cw_lap[11] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1101, 8'hA3};
    cw_lap[12] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1011, 8'hA3};
    cw_lap[13] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1011, 8'hA3};
    cw_lap[14] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b0111, 8'hA3};
    cw_lap[15] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b0111, 8'hA3};
    cw_lap[16] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b0111, 8'h9C};

    ccw[0] = '{1'b1, 1'b1, 1'b1, 2'd3, 4'b0111, 8'h9C};
    ccw[1] = '{1'b0, 1'b1, 1'b1, 2'd3, 4'b0111, 8'h9C};
    ccw[2] = '{1'b0, 1'b1, 1'b1, 2'd3, 4'b0111, 8'hA3};
    ccw[3] = '{1'b0, 1'b1, 1'b1, 2'd3, 4'b0111, 8'hA3};
    ccw[4] = '{1'b0, 1'b1, 1'b1, 2'd3, 4'b1011, 8'hA3};

    #1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(cw_lap[i].rst, cw_lap[i].en, cw_lap[i].dir, cw_lap[i].speed,
                    1'b1, cw_lap[i].an, cw_lap[i].sseg, $sformatf("cw_lap[%0d]", i));
    end

    for (int i = 0; i < 5; i++) begin
      applyStimulus(ccw[i].rst, ccw[i].en, ccw[i].dir, ccw[i].speed,
                    1'b1, ccw[i].an, ccw[i].sseg, $sformatf("ccw_wrap[%0d]", i));
    end

    // Pause mid-lap for 40 cycles, then resume from the held position.
    runModel(1'b1, 1'b1, 1'b0, 2'd3, 1, "pause_reset");
    runModel(1'b0, 1'b1, 1'b0, 2'd3, 7, "pause_pre");
    runModel(1'b0, 1'b0, 1'b0, 2'd3, 40, "pause_hold");
    runModel(1'b0, 1'b1, 1'b0, 2'd3, 6, "pause_resume");

    // Slowest rate, then switch to speed 2 without restarting the prescaler.
    runModel(1'b1, 1'b1, 1'b0, 2'd0, 1, "speed_reset");
    runModel(1'b0, 1'b1, 1'b0, 2'd0, 15, "speed0_wait");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'b1011, 8'h9C, "speed0_first_step");
    runModel(1'b0, 1'b1, 1'b0, 2'd0, 16, "speed0_second");
    runModel(1'b0, 1'b1, 1'b0, 2'd2, 12, "speed2");

    // Reset asserted for one cycle at pos=5.
    runModel(1'b1, 1'b1, 1'b0, 2'd3, 1, "midreset_init");
    runModel(1'b0, 1'b1, 1'b0, 2'd3, 10, "midreset_run");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 4'b0111, 8'h9C, "midreset_pulse");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 4'b0111, 8'h9C, "midreset_hold");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1011, 8'h9C, "midreset_first_step");

    // Direction flips on the very tick that would leave pos=2.
    runModel(1'b1, 1'b1, 1'b0, 2'd3, 1, "dirflip_reset");
    runModel(1'b0, 1'b1, 1'b0, 2'd3, 5, "dirflip_run");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1011, 8'h9C, "dirflip_tick");

    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
